// File: rtl/mem_stage.sv
// Mem stage of the 5-stage MIPS pipeline: byte-lane data memory plus the Mem/Wr register.
// Optional feature macro: MEM_ALIGN_CHK_EN adds the align_err output and misaligned-access suppression.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Mem_op,
  input  logic [4:0]  Mem_Reg,
  input  logic        Mem_RegWr,
  input  logic        Mem_MemtoReg,
  input  logic        Mem_MemWr,
  input  logic [31:0] Mem_alure,
  input  logic [31:0] Mem_busB,
  input  logic [29:0] Mem_PC,
  input  logic        stall,
  input  logic        flush,
  output logic [5:0]  Wr_op,
  output logic [4:0]  Wr_Reg,
  output logic        Wr_RegWr,
  output logic        Wr_MemtoReg,
  output logic [31:0] Wr_alure,
  output logic [29:0] Wr_PC,
`ifdef MEM_ALIGN_CHK_EN
  output logic        align_err,
`endif
  output logic [31:0] Wr_dout
);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
`ifdef MEM_ALIGN_CHK_EN
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
`endif

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] r_mem [0:DEPTH-1];

  logic [ADDR_W-1:0] w_idx;
  logic              w_is_sw;
  logic              w_is_sh;
  logic              w_is_sb;
  logic              w_misalign;
  logic              w_store_en;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rd_word;
  logic              w_unused_ok;

  // Address bits above the word index alias onto the same array.
  assign w_idx       = Mem_alure[ADDR_W+1:2];
  assign w_unused_ok = ^Mem_alure[31:ADDR_W+2];
  assign w_rd_word   = r_mem[w_idx];

  assign w_is_sw = (Mem_op == OP_SW);
  assign w_is_sh = (Mem_op == OP_SH);
  assign w_is_sb = (Mem_op == OP_SB);

`ifdef MEM_ALIGN_CHK_EN
  always_comb begin
    w_misalign = 1'b0;
    if ((Mem_op == OP_SW) || (Mem_op == OP_LW))
      w_misalign = (Mem_alure[1:0] != 2'b00);
    else if ((Mem_op == OP_SH) || (Mem_op == OP_LH) || (Mem_op == OP_LHU))
      w_misalign = Mem_alure[0];
  end
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = Mem_busB;
    if (w_is_sw) begin
      w_be    = 4'b1111;
      w_wdata = Mem_busB;
    end else if (w_is_sh) begin
      w_be    = Mem_alure[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{Mem_busB[15:0]}};
    end else if (w_is_sb) begin
      w_be    = 4'b0001 << Mem_alure[1:0];
      w_wdata = {4{Mem_busB[7:0]}};
    end
  end

  assign w_store_en = Mem_MemWr & ~rst & ~flush & ~stall & ~w_misalign
                    & (w_is_sw | w_is_sh | w_is_sb);

  // Array is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Wr_dout samples the pre-store word, giving read-before-write on a same-word store.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      Wr_op       <= '0;
      Wr_Reg      <= '0;
      Wr_RegWr    <= 1'b0;
      Wr_MemtoReg <= 1'b0;
      Wr_alure    <= '0;
      Wr_PC       <= '0;
      Wr_dout     <= '0;
`ifdef MEM_ALIGN_CHK_EN
      align_err   <= 1'b0;
`endif
    end else if (!stall) begin
      Wr_op       <= Mem_op;
      Wr_Reg      <= Mem_Reg;
      Wr_RegWr    <= Mem_RegWr & ~w_misalign;
      Wr_MemtoReg <= Mem_MemtoReg;
      Wr_alure    <= Mem_alure;
      Wr_PC       <= Mem_PC;
      Wr_dout     <= w_rd_word;
`ifdef MEM_ALIGN_CHK_EN
      align_err   <= w_misalign;
`endif
    end
  end

endmodule
